// File: rtl/rr_mux_select_arbiter.sv
// Round-robin arbiter that produces the Select index for nbit_mux.
// One channel is granted at a time. The grant stays frozen until the consumer
// acknowledges it or the hold timeout expires. The next search then starts at
// the channel after the one that was just released. Every output is registered.
module rr_mux_select_arbiter #(
    parameter int DATA_IN  = 64,
    parameter int HOLD_MAX = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [DATA_IN-1:0]         req,
    input  logic                       grant_ack,
    output logic [$clog2(DATA_IN)-1:0] sel,
    output logic [DATA_IN-1:0]         grant_onehot,
    output logic                       grant_valid,
    output logic                       timeout
);

    localparam int SEL_W = $clog2(DATA_IN);
    // One spare bit lets the counter saturate instead of wrapping.
    localparam int CNT_W = $clog2(HOLD_MAX) + 1;
    // The release point is clamped to 0 when HOLD_MAX is 0. In that case the
    // timeout path is disabled by TIMEOUT_EN, so the value is never used.
    localparam int HOLD_LAST_I = (HOLD_MAX > 0) ? (HOLD_MAX - 1) : 0;
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam bit               TIMEOUT_EN = (HOLD_MAX != 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] ptr_s;
    logic [CNT_W-1:0] hold_cnt_r;
    logic [CNT_W-1:0] hold_cnt_s;
    logic [SEL_W-1:0] sel_s;
    logic             grant_valid_s;
    logic [DATA_IN-1:0] grant_onehot_s;
    logic             timeout_s;
    logic [SEL_W:0]   pick_s;

    // Find the first set request at or above base, wrapping past the top.
    // The result is {found, index}.
    function automatic logic [SEL_W:0] rr_pick(
        input logic [DATA_IN-1:0] req_v,
        input logic [SEL_W-1:0]   base
    );
        logic             found;
        logic [SEL_W-1:0] pick;
        logic [SEL_W-1:0] idx;
        found = 1'b0;
        pick  = base;
        for (int i = 0; i < DATA_IN; i++) begin
            // The truncating add provides the DATA_IN-1 -> 0 wrap.
            idx = base + SEL_W'(i);
            if (!found && req_v[idx]) begin
                found = 1'b1;
                pick  = idx;
            end else begin
                found = found;
            end
        end
        return {found, pick};
    endfunction

    // Expand a binary index into its one-hot form.
    function automatic logic [DATA_IN-1:0] to_onehot(input logic [SEL_W-1:0] idx);
        logic [DATA_IN-1:0] one;
        one = {{(DATA_IN-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_s        = state_r;
        ptr_s          = ptr_r;
        sel_s          = sel;
        hold_cnt_s     = hold_cnt_r;
        grant_valid_s  = 1'b0;
        timeout_s      = 1'b0;
        grant_onehot_s = '0;
        pick_s         = rr_pick(req, ptr_r);

        case (state_r)
            ST_IDLE: begin
                if (enable && pick_s[SEL_W]) begin
                    state_s       = ST_GRANT;
                    sel_s         = pick_s[SEL_W-1:0];
                    grant_valid_s = 1'b1;
                    hold_cnt_s    = '0;
                end else begin
                    // sel keeps its last value while nothing is granted.
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // req and enable are deliberately ignored here. The grant is
                // frozen until it is acknowledged or it times out.
                if (grant_ack) begin
                    // Ack takes precedence, so a coincident timeout is suppressed.
                    state_s = ST_IDLE;
                    ptr_s   = sel + SEL_W'(1);
                end else if (TIMEOUT_EN && (hold_cnt_r == HOLD_LAST)) begin
                    state_s   = ST_IDLE;
                    ptr_s     = sel + SEL_W'(1);
                    timeout_s = 1'b1;
                end else begin
                    grant_valid_s = 1'b1;
                    if (hold_cnt_r != CNT_MAX) begin
                        hold_cnt_s = hold_cnt_r + CNT_W'(1);
                    end else begin
                        hold_cnt_s = hold_cnt_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (grant_valid_s) begin
            grant_onehot_s = to_onehot(sel_s);
        end else begin
            grant_onehot_s = '0;
        end
    end

    // Register the controller state, the pointer, the hold counter and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ptr_r        <= '0;
            hold_cnt_r   <= '0;
            sel          <= '0;
            grant_valid  <= 1'b0;
            grant_onehot <= '0;
            timeout      <= 1'b0;
        end else begin
            state_r      <= state_s;
            ptr_r        <= ptr_s;
            hold_cnt_r   <= hold_cnt_s;
            sel          <= sel_s;
            grant_valid  <= grant_valid_s;
            grant_onehot <= grant_onehot_s;
            timeout      <= timeout_s;
        end
    end

endmodule

// File: tb/tb_rr_mux_select_arbiter.sv
// Self-checking bench for rr_mux_select_arbiter (64 channels, hold limit 4).
// It combines a table of directed vectors, hand-written multi-cycle sequences,
// and a random phase that is compared against a behavioural arbiter model.
module tb_rr_mux_select_arbiter;

    localparam int N    = 64;
    localparam int HOLD = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          enable    = 1'b0;
    logic          grant_ack = 1'b0;
    logic [N-1:0]  req       = '0;
    logic [5:0]    sel;
    logic [N-1:0]  grant_onehot;
    logic          grant_valid;
    logic          timeout;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: granted flag, priority start, current winner,
    // number of cycles the grant has been visible, and the timeout pulse.
    bit m_gv;
    bit m_to;
    int m_ptr;
    int m_sel;
    int m_age;

    typedef struct {
        logic        en;
        logic [63:0] rq;
        logic        ack;
        logic        gv;
        int          sl;
        logic        to;
    } vec_t;

    vec_t tbl[$];

    rr_mux_select_arbiter #(.DATA_IN(N), .HOLD_MAX(HOLD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .req          (req),
        .grant_ack    (grant_ack),
        .sel          (sel),
        .grant_onehot (grant_onehot),
        .grant_valid  (grant_valid),
        .timeout      (timeout)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic model_reset();
        m_gv  = 1'b0;
        m_to  = 1'b0;
        m_ptr = 0;
        m_sel = 0;
        m_age = 0;
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_update();
        bit was_gv;
        was_gv = m_gv;
        m_to   = 1'b0;
        if (!was_gv) begin
            if (enable && (req != '0)) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (req[idx]) begin
                        m_sel = idx;
                        m_gv  = 1'b1;
                        m_age = 1;
                        break;
                    end
                end
            end
        end else if (grant_ack) begin
            m_gv  = 1'b0;
            m_ptr = (m_sel + 1) % N;
        end else if (m_age == HOLD) begin
            m_gv  = 1'b0;
            m_ptr = (m_sel + 1) % N;
            m_to  = 1'b1;
        end else begin
            m_age = m_age + 1;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input bit egv, input int esel, input bit eto);
        logic [N-1:0] eoh;
        logic [5:0]   es;
        es  = 6'(esel);
        eoh = egv ? (64'd1 << esel) : 64'd0;
        vectors++;
        if (grant_valid !== egv || sel !== es || grant_onehot !== eoh || timeout !== eto) begin
            miscompares++;
            $display("FAIL %s: got gv=%0b sel=%0d oh=%h to=%0b, expected gv=%0b sel=%0d oh=%h to=%0b",
                     name, grant_valid, sel, grant_onehot, timeout, egv, es, eoh, eto);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_gv, m_sel, m_to);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        grant_ack = 1'b0;
        #3;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_vec(input logic en, input logic [63:0] rq, input logic ack,
                           input logic gv, input int sl, input logic to);
        vec_t v;
        v.en  = en;
        v.rq  = rq;
        v.ack = ack;
        v.gv  = gv;
        v.sl  = sl;
        v.to  = to;
        tbl.push_back(v);
    endtask

    initial begin
        model_reset();

        // Two requesters alternate, ack arrives on the fourth grant cycle.
        for (int r = 0; r < 4; r++) begin
            add_vec(1'b1, 64'h24, 1'b0, 1'b1, (r % 2 == 0) ? 2 : 5, 1'b0);
            add_vec(1'b1, 64'h24, 1'b0, 1'b1, (r % 2 == 0) ? 2 : 5, 1'b0);
            add_vec(1'b1, 64'h24, 1'b0, 1'b1, (r % 2 == 0) ? 2 : 5, 1'b0);
            add_vec(1'b1, 64'h24, 1'b1, 1'b0, (r % 2 == 0) ? 2 : 5, 1'b0);
        end
        // Ack lands on the same cycle as the timeout limit, so ack wins.
        add_vec(1'b1, 64'h24, 1'b0, 1'b1, 2, 1'b0);
        add_vec(1'b1, 64'h24, 1'b0, 1'b1, 2, 1'b0);
        add_vec(1'b1, 64'h24, 1'b0, 1'b1, 2, 1'b0);
        add_vec(1'b1, 64'h24, 1'b0, 1'b1, 2, 1'b0);
        add_vec(1'b1, 64'h24, 1'b1, 1'b0, 2, 1'b0);
        // Disabled: no grant, and an ack in IDLE is ignored.
        add_vec(1'b0, 64'h24, 1'b0, 1'b0, 2, 1'b0);
        add_vec(1'b0, 64'h24, 1'b1, 1'b0, 2, 1'b0);
        // Timeout with no ack, then the next channel is granted.
        add_vec(1'b1, 64'h3,  1'b0, 1'b1, 0, 1'b0);
        add_vec(1'b1, 64'h3,  1'b0, 1'b1, 0, 1'b0);
        add_vec(1'b1, 64'h3,  1'b0, 1'b1, 0, 1'b0);
        add_vec(1'b1, 64'h3,  1'b0, 1'b1, 0, 1'b0);
        add_vec(1'b1, 64'h3,  1'b0, 1'b0, 0, 1'b1);
        add_vec(1'b1, 64'h3,  1'b0, 1'b1, 1, 1'b0);
        add_vec(1'b1, 64'h3,  1'b1, 1'b0, 1, 1'b0);

        // Asynchronous reset with no clock edge in between.
        #1 rst_n = 1'b0;
        #2 check("reset_state", 1'b0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // No requests: nothing granted, nothing times out.
        enable = 1'b1;
        req    = '0;
        repeat (20) begin
            step();
            check("idle_no_req", 1'b0, 0, 1'b0);
        end

        // Directed table.
        do_reset();
        foreach (tbl[i]) begin
            enable    = tbl[i].en;
            req       = tbl[i].rq;
            grant_ack = tbl[i].ack;
            step();
            check($sformatf("table[%0d]", i), tbl[i].gv, tbl[i].sl, tbl[i].to);
        end

        // All requesters active: the grant walks 0..63 and wraps back to 0.
        do_reset();
        enable = 1'b1;
        req    = '1;
        for (int k = 0; k <= N; k++) begin
            grant_ack = 1'b0;
            step();
            check("rr_walk_grant", 1'b1, k % N, 1'b0);
            grant_ack = 1'b1;
            step();
            check("rr_walk_release", 1'b0, k % N, 1'b0);
        end

        // The grant holds after req and enable drop, and there is no regrant while disabled.
        do_reset();
        grant_ack = 1'b0;
        enable    = 1'b1;
        req       = 64'd1 << 9;
        step();
        check("hold_grant9", 1'b1, 9, 1'b0);
        req    = '0;
        enable = 1'b0;
        step();
        check("hold_after_drop", 1'b1, 9, 1'b0);
        step();
        check("hold_after_drop", 1'b1, 9, 1'b0);
        grant_ack = 1'b1;
        step();
        check("hold_ack_release", 1'b0, 9, 1'b0);
        grant_ack = 1'b0;
        req       = '1;
        repeat (5) begin
            step();
            check("disabled_no_grant", 1'b0, 9, 1'b0);
        end

        // Reset mid-grant clears outputs at once, and channel 0 then has priority.
        do_reset();
        enable = 1'b1;
        req    = 64'd1 << 40;
        step();
        check("pre_reset_grant40", 1'b1, 40, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("async_reset_mid_grant", 1'b0, 0, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req   = '1;
        step();
        check("post_reset_first", 1'b1, 0, 1'b0);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int mode;
            enable = ($urandom_range(0, 9) != 0);
            mode   = $urandom_range(0, 3);
            case (mode)
                0:       req = '0;
                1:       req = 64'd1 << $urandom_range(0, 63);
                2:       req = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                default: req = {$urandom, $urandom};
            endcase
            grant_ack = ($urandom_range(0, 3) == 0);
            step();
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
